// File: rtl/ffd_write_arbiter_if.sv
// Handshake bundle between N requesters, the write arbiter and the shared
// enabled D register it feeds.
interface ffd_write_arbiter_if #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int CW = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           ff_enable;
    logic [W-1:0]   ff_d;
    logic           busy;
    logic [CW-1:0]  write_count;

    modport master (
        output req, data,
        input  grant, ack, ff_enable, ff_d, busy, write_count
    );

    modport slave (
        input  req, data,
        output grant, ack, ff_enable, ff_d, busy, write_count
    );
endinterface

// File: rtl/ffd_write_arbiter.sv
// Round-robin arbiter owning the enable/d inputs of one shared W-bit register.
// Each transaction is IDLE-sample -> WRITE (enable for one clock) -> ACK.
module ffd_write_arbiter #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic               clk,
    input  logic               rst,
    ffd_write_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t         state_reg;
    logic [PW-1:0]  ptr_reg;
    logic [PW-1:0]  winner_reg;
    logic [N-1:0]   grant_reg;
    logic [N-1:0]   ack_reg;
    logic           ff_enable_reg;
    logic [W-1:0]   ff_d_reg;
    logic           busy_reg;
    logic [CW-1:0]  write_count_reg;

    logic [W-1:0]   data_slice [N];
    logic [PW-1:0]  pick_next;
    logic           pick_valid;
    logic [PW-1:0]  ptr_next;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign data_slice[gi] = bus.data[gi*W +: W];
        end
    endgenerate

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        logic [PW:0] idx_w;
        pick_next  = '0;
        pick_valid = 1'b0;
        idx_w      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_w = {1'b0, ptr_reg} + (PW+1)'(k);
            if (idx_w >= (PW+1)'(N)) begin
                idx_w = idx_w - (PW+1)'(N);
            end
            if (bus.req[idx_w[PW-1:0]]) begin
                pick_next  = idx_w[PW-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    assign ptr_next = (winner_reg == PW'(N - 1)) ? '0 : winner_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            winner_reg      <= '0;
            grant_reg       <= '0;
            ack_reg         <= '0;
            ff_enable_reg   <= 1'b0;
            ff_d_reg        <= '0;
            busy_reg        <= 1'b0;
            write_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= '0;
                    if (pick_valid) begin
                        winner_reg    <= pick_next;
                        grant_reg     <= N'(1) << pick_next;
                        busy_reg      <= 1'b1;
                        ff_enable_reg <= 1'b1;
                        ff_d_reg      <= data_slice[pick_next];
                        state_reg     <= WRITE;
                    end else begin
                        grant_reg     <= '0;
                        busy_reg      <= 1'b0;
                        ff_enable_reg <= 1'b0;
                        ff_d_reg      <= '0;
                    end
                end
                WRITE: begin
                    // The shared register captures ff_d at this edge.
                    ff_enable_reg   <= 1'b0;
                    ff_d_reg        <= '0;
                    ack_reg         <= N'(1) << winner_reg;
                    write_count_reg <= write_count_reg + 1'b1;
                    ptr_reg         <= ptr_next;
                    state_reg       <= ACK;
                end
                ACK: begin
                    ack_reg   <= '0;
                    grant_reg <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    grant_reg     <= '0;
                    ack_reg       <= '0;
                    ff_enable_reg <= 1'b0;
                    ff_d_reg      <= '0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = grant_reg;
    assign bus.ack         = ack_reg;
    assign bus.ff_enable   = ff_enable_reg;
    assign bus.ff_d        = ff_d_reg;
    assign bus.busy        = busy_reg;
    assign bus.write_count = write_count_reg;
endmodule

// File: tb/tb_ffd_write_arbiter.sv
// Randomized bench for ffd_write_arbiter: a transaction-level round-robin model
// plus a model of the shared enabled register it drives.
module tb_ffd_write_arbiter;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ffd_write_arbiter_if #(.N(N), .W(W), .CW(CW)) bus ();

    ffd_write_arbiter #(.N(N), .W(W), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // The shared register: resets on rst, captures d when enabled.
    logic [W-1:0] q_reg;
    always_ff @(posedge clk) begin
        if (rst)               q_reg <= '0;
        else if (bus.ff_enable) q_reg <= bus.ff_d;
    end

    int checks = 0;
    int errors = 0;

    int            model_ptr   = 0;
    logic [CW-1:0] model_count = '0;

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    // Caller is 1 time unit after an edge with the DUT in IDLE.
    task automatic txn(input logic [N-1:0] r, input logic [N*W-1:0] d,
                       input bit perturb, input string name);
        int            w;
        logic [N-1:0]  oh;
        logic [W-1:0]  exp_d;
        bus.req  = r;
        bus.data = d;
        w = pick(r);
        @(posedge clk); #1;
        if (w < 0) begin
            checks++;
            if ({bus.grant, bus.ack, bus.ff_enable, bus.ff_d, bus.busy, bus.write_count} !==
                {{N{1'b0}}, {N{1'b0}}, 1'b0, {W{1'b0}}, 1'b0, model_count}) begin
                errors++;
                $display("FAIL %s idle: grant=%b ack=%b en=%b d=%h busy=%b cnt=%0d, want zeros cnt=%0d",
                         name, bus.grant, bus.ack, bus.ff_enable, bus.ff_d, bus.busy,
                         bus.write_count, model_count);
            end
            $display("txn %s: req=%b idle", name, r);
            return;
        end
        oh    = N'(1) << w;
        exp_d = d[w*W +: W];
        checks++;
        if ({bus.grant, bus.ack, bus.ff_enable, bus.ff_d, bus.busy} !==
            {oh, {N{1'b0}}, 1'b1, exp_d, 1'b1}) begin
            errors++;
            $display("FAIL %s write: grant=%b ack=%b en=%b d=%h busy=%b, want grant=%b ack=0 en=1 d=%h busy=1",
                     name, bus.grant, bus.ack, bus.ff_enable, bus.ff_d, bus.busy, oh, exp_d);
        end
        if (perturb) begin
            bus.data = ~d;
            bus.req  = ~r;
        end
        @(posedge clk); #1;
        model_count = model_count + 1'b1;
        model_ptr   = (w + 1) % N;
        checks++;
        if ({bus.grant, bus.ack, bus.ff_enable, bus.ff_d, bus.busy, bus.write_count, q_reg} !==
            {oh, oh, 1'b0, {W{1'b0}}, 1'b1, model_count, exp_d}) begin
            errors++;
            $display("FAIL %s ack: grant=%b ack=%b en=%b d=%h busy=%b cnt=%0d q=%h, want grant=ack=%b en=0 d=0 busy=1 cnt=%0d q=%h",
                     name, bus.grant, bus.ack, bus.ff_enable, bus.ff_d, bus.busy,
                     bus.write_count, q_reg, oh, model_count, exp_d);
        end
        bus.req  = r & ~oh;
        bus.data = d;
        @(posedge clk); #1;
        checks++;
        if ({bus.grant, bus.ack, bus.ff_enable, bus.ff_d, bus.busy, bus.write_count} !==
            {{N{1'b0}}, {N{1'b0}}, 1'b0, {W{1'b0}}, 1'b0, model_count}) begin
            errors++;
            $display("FAIL %s release: grant=%b ack=%b en=%b d=%h busy=%b cnt=%0d, want zeros cnt=%0d",
                     name, bus.grant, bus.ack, bus.ff_enable, bus.ff_d, bus.busy,
                     bus.write_count, model_count);
        end
        $display("txn %s: req=%b winner=%0d d=%h count=%0d", name, r, w, exp_d, model_count);
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({bus.grant, bus.ack, bus.ff_enable, bus.ff_d, bus.busy, bus.write_count} !==
            {{N{1'b0}}, {N{1'b0}}, 1'b0, {W{1'b0}}, 1'b0, {CW{1'b0}}}) begin
            errors++;
            $display("FAIL %s: grant=%b ack=%b en=%b d=%h busy=%b cnt=%0d, want all zero",
                     name, bus.grant, bus.ack, bus.ff_enable, bus.ff_d, bus.busy, bus.write_count);
        end
        $display("txn %s: reset values checked", name);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr   = 0;
        model_count = '0;
    endtask

    task automatic test_reset();
        bus.req  = '0;
        bus.data = '0;
        apply_reset();
        check_reset_values("reset");
    endtask

    task automatic test_single();
        txn(4'b0010, 16'h0090, 1'b0, "single");
    endtask

    task automatic test_all_requesting();
        logic [N-1:0] r;
        apply_reset();
        r = 4'b1111;
        for (int i = 0; i < N; i++) begin
            txn(r, 16'h8765, 1'b0, "all_req");
            r = r & ~(N'(1) << i);
        end
    endtask

    task automatic test_pointer_wrap();
        txn(4'b0100, 16'h0A00, 1'b0, "wrap_r2");
        txn(4'b0101, 16'h0B0C, 1'b0, "wrap_first");
        txn(4'b0100, 16'h0B0C, 1'b0, "wrap_second");
    endtask

    task automatic test_data_change();
        txn(4'b0001, 16'h0003, 1'b1, "data_change");
    endtask

    task automatic test_reset_mid_write();
        bus.req  = 4'b0100;
        bus.data = 16'h0500;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr   = 0;
        model_count = '0;
        check_reset_values("reset_mid_write");
        checks++;
        if (q_reg !== '0) begin
            errors++;
            $display("FAIL reset_mid_write q: q=%h, want 0", q_reg);
        end
        txn(4'b1111, 16'h4321, 1'b0, "after_reset_write");
    endtask

    task automatic test_reset_in_ack();
        bus.req  = 4'b1000;
        bus.data = 16'h7000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr   = 0;
        model_count = '0;
        check_reset_values("reset_in_ack");
        bus.req = '0;
    endtask

    task automatic test_random();
        logic [N-1:0]   r;
        logic [N*W-1:0] d;
        for (int i = 0; i < 340; i++) begin
            r = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 7) == 0) r = '0;
            d = (N*W)'($urandom);
            txn(r, d, bit'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        txn(4'b0000, 16'h0000, 1'b0, "idle");
        test_all_requesting();
        test_pointer_wrap();
        test_data_change();
        test_reset_mid_write();
        test_reset_in_ack();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
